cbfp_block_norm: RTL and testbench

- Convergent block-floating-point (CBFP) normaliser placed directly downstream of the twiddle-multiply stage.
- Arms on the alert_CBFP pulse and collects one block of BLOCK_LEN complex products from the twiddle multiplier.
- Finds the minimum count of redundant sign bits over all real and imaginary parts in the block.
- Replays the block left-shifted by that common amount and narrowed to OUT_W bits, with the shift index reported per sample for later exponent compensation.

---
 rtl/cbfp_block_norm.sv | 263 ++++++++++++++++++++++++++
 tb/tb_cbfp_block_norm.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cbfp_block_norm.sv
// ---------------------------------------------------------------------------
// cbfp_block_norm
//
// Convergent block-floating-point normaliser sitting after the twiddle
// multiplier. An alert_cbfp pulse arms the block; BLOCK_LEN complex samples
// are buffered while the smallest redundant-sign-bit count over every real
// and imaginary part is tracked. The block is then replayed, each component
// left-shifted by that common count and narrowed to OUT_W bits. The shift
// is reported on out_idx so later stages can compensate the exponent.
//
// Optional build macro:
//   CBFP_ROUND_EN  round half up on the narrowing step, saturating positive
//                  overflow to the largest OUT_W value. Undefined: truncate.
//
// Ports:
//   clk         clock
//   rstn        asynchronous active-low reset
//   alert_cbfp  one-cycle pulse marking the start of a block
//   in_valid    input sample qualifier
//   in_re/in_im signed DATA_W input components
//   out_valid   output sample qualifier
//   out_re/out_im signed OUT_W normalised components
//   out_idx     common shift applied to the current block
//   out_last    high with the final sample of the block
//   busy        high while collecting or emitting
//   ovf         sticky: an input was dropped while emitting
//
// Handshake: in_valid qualifies in_re/in_im in the cycle it is high; there is
// no backpressure, so samples or alerts offered during EMIT are dropped and
// flagged on ovf. out_valid qualifies out_re/out_im/out_idx/out_last for one
// cycle each; there is no ready, the consumer must take every sample.
// ---------------------------------------------------------------------------
module cbfp_block_norm #(
    parameter int DATA_W    = 23,
    parameter int OUT_W     = 11,
    parameter int BLOCK_LEN = 16
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      alert_cbfp,
    input  logic                      in_valid,
    input  logic [DATA_W-1:0]         in_re,
    input  logic [DATA_W-1:0]         in_im,
    output logic                      out_valid,
    output logic [OUT_W-1:0]          out_re,
    output logic [OUT_W-1:0]          out_im,
    output logic [$clog2(DATA_W)-1:0] out_idx,
    output logic                      out_last,
    output logic                      busy,
    output logic                      ovf
);

    localparam int IDX_W = $clog2(DATA_W);
    localparam int CNT_W = $clog2(BLOCK_LEN);

    localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(DATA_W - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLOCK_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_EMIT    = 2'd2
    } state_t;

    // Number of consecutive bits directly below the sign bit that equal it.
    function automatic logic [IDX_W-1:0] lsb_count(input logic [DATA_W-1:0] x);
        logic             run;
        logic [IDX_W-1:0] n;
        run = 1'b1;
        n   = '0;
        for (int i = DATA_W - 2; i >= 0; i--) begin
            if (run && (x[i] == x[DATA_W-1])) begin
                n = n + IDX_ONE;
            end else begin
                run = 1'b0;
            end
        end
        return n;
    endfunction

    // Shift by the block minimum and keep the top OUT_W bits. The shift never
    // overflows because no component has fewer redundant sign bits than sh.
    function automatic logic [OUT_W-1:0] narrow(input logic [DATA_W-1:0] x,
                                                 input logic [IDX_W-1:0]  sh);
        logic [DATA_W-1:0] s;
`ifdef CBFP_ROUND_EN
        logic [OUT_W:0]    ext;
`endif
        s = x << sh;
`ifdef CBFP_ROUND_EN
        // One guard bit above the result catches the only possible overflow:
        // a positive value rounding past the largest representable code.
        ext = {s[DATA_W-1], s[DATA_W-1 -: OUT_W]}
            + {{OUT_W{1'b0}}, s[DATA_W-OUT_W-1]};
        if (ext[OUT_W] != ext[OUT_W-1]) begin
            return {1'b0, {(OUT_W-1){1'b1}}};
        end
        return ext[OUT_W-1:0];
`else
        return s[DATA_W-1 -: OUT_W];
`endif
    endfunction

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   min_q, min_d;
    logic               out_valid_q, out_valid_d;
    logic [OUT_W-1:0]   out_re_q, out_re_d;
    logic [OUT_W-1:0]   out_im_q, out_im_d;
    logic [IDX_W-1:0]   out_idx_q, out_idx_d;
    logic               out_last_q, out_last_d;
    logic               ovf_q, ovf_d;

    // Sample buffer: {re, im} per entry; contents need no reset.
    logic [2*DATA_W-1:0] buf_mem [BLOCK_LEN];
    logic                wr_en;
    logic [CNT_W-1:0]    wr_addr;

    logic [2*DATA_W-1:0] rd_word;
    logic [DATA_W-1:0]   rd_re;
    logic [DATA_W-1:0]   rd_im;

    logic [IDX_W-1:0]    lsb_re;
    logic [IDX_W-1:0]    lsb_im;
    logic [IDX_W-1:0]    smp_min;
    logic [IDX_W-1:0]    run_min;

    assign rd_word = buf_mem[cnt_q];
    assign rd_re   = rd_word[2*DATA_W-1:DATA_W];
    assign rd_im   = rd_word[DATA_W-1:0];

    assign lsb_re  = lsb_count(in_re);
    assign lsb_im  = lsb_count(in_im);
    assign smp_min = (lsb_re < lsb_im) ? lsb_re : lsb_im;
    assign run_min = (smp_min < min_q) ? smp_min : min_q;

    // ------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        min_d       = min_q;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        out_re_d    = out_re_q;
        out_im_d    = out_im_q;
        out_idx_d   = out_idx_q;
        ovf_d       = ovf_q;
        wr_en       = 1'b0;
        wr_addr     = cnt_q;

        unique case (state_q)
            S_IDLE: begin
                if (alert_cbfp) begin
                    state_d = S_COLLECT;
                    cnt_d   = '0;
                    min_d   = IDX_MAX;
                    // A sample arriving with the alert is sample 0.
                    if (in_valid) begin
                        wr_en   = 1'b1;
                        wr_addr = '0;
                        cnt_d   = CNT_ONE;
                        min_d   = smp_min;
                    end
                end
            end

            S_COLLECT: begin
                if (in_valid) begin
                    wr_en   = 1'b1;
                    wr_addr = cnt_q;
                    min_d   = run_min;
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_EMIT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end

            S_EMIT: begin
                out_valid_d = 1'b1;
                out_re_d    = narrow(rd_re, min_q);
                out_im_d    = narrow(rd_im, min_q);
                out_idx_d   = min_q;
                cnt_d       = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    out_last_d = 1'b1;
                    cnt_d      = '0;
                    state_d    = S_IDLE;
                    // The buffer slot for sample 0 is free once the last
                    // sample is read, so a new block may start right here.
                    if (alert_cbfp) begin
                        state_d = S_COLLECT;
                        min_d   = IDX_MAX;
                        if (in_valid) begin
                            wr_en   = 1'b1;
                            wr_addr = '0;
                            cnt_d   = CNT_ONE;
                            min_d   = smp_min;
                        end
                    end else if (in_valid) begin
                        ovf_d = 1'b1;
                    end
                end else if (alert_cbfp || in_valid) begin
                    ovf_d = 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                min_d   = IDX_MAX;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            min_q       <= IDX_MAX;
            out_valid_q <= 1'b0;
            out_re_q    <= '0;
            out_im_q    <= '0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            min_q       <= min_d;
            out_valid_q <= out_valid_d;
            out_re_q    <= out_re_d;
            out_im_q    <= out_im_d;
            out_idx_q   <= out_idx_d;
            out_last_q  <= out_last_d;
            ovf_q       <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            buf_mem[wr_addr] <= {in_re, in_im};
        end
    end

    assign out_valid = out_valid_q;
    assign out_re    = out_re_q;
    assign out_im    = out_im_q;
    assign out_idx   = out_idx_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q != S_IDLE);
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_cbfp_block_norm.sv
// ---------------------------------------------------------------------------
// tb_cbfp_block_norm
//
// Randomised block stimulus against an arithmetic reference model. Each block
// sent pushes its expected output samples into exp_q; a monitor on the
// falling edge pops and compares whenever out_valid is high.
// ---------------------------------------------------------------------------
module tb_cbfp_block_norm;

    localparam int DATA_W    = 23;
    localparam int OUT_W     = 11;
    localparam int BLOCK_LEN = 16;
    localparam int IDX_W     = $clog2(DATA_W);
    localparam int EXP_W     = 1 + IDX_W + 2 * OUT_W;

    // ---------------- clock / reset ----------------
    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              alert_cbfp = 1'b0;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_re = '0;
    logic [DATA_W-1:0] in_im = '0;
    logic              out_valid;
    logic [OUT_W-1:0]  out_re;
    logic [OUT_W-1:0]  out_im;
    logic [IDX_W-1:0]  out_idx;
    logic              out_last;
    logic              busy;
    logic              ovf;

    always #5 clk = ~clk;

    cbfp_block_norm #(
        .DATA_W    (DATA_W),
        .OUT_W     (OUT_W),
        .BLOCK_LEN (BLOCK_LEN)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .alert_cbfp (alert_cbfp),
        .in_valid   (in_valid),
        .in_re      (in_re),
        .in_im      (in_im),
        .out_valid  (out_valid),
        .out_re     (out_re),
        .out_im     (out_im),
        .out_idx    (out_idx),
        .out_last   (out_last),
        .busy       (busy),
        .ovf        (ovf)
    );

    // ---------------- scoreboard state ----------------
    int               checks = 0;
    int               errors = 0;
    logic [EXP_W-1:0] exp_q[$];
    logic [DATA_W-1:0] blk_re [BLOCK_LEN];
    logic [DATA_W-1:0] blk_im [BLOCK_LEN];
    int               run_len = 0;

    task automatic check(input string name, input longint got, input longint want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, want, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Redundant sign bits = largest n with x representable in DATA_W-n bits.
    function automatic int lsb_model(input logic [DATA_W-1:0] v);
        longint x;
        longint lim;
        x = longint'($signed(v));
        for (int n = DATA_W - 1; n >= 0; n--) begin
            lim = longint'(1) << (DATA_W - 1 - n);
            if (x >= -lim && x < lim) return n;
        end
        return 0;
    endfunction

    function automatic logic [OUT_W-1:0] narrow_model(input logic [DATA_W-1:0] v, input int sh);
        longint s;
        longint r;
        s = longint'($signed(v)) * (longint'(1) << sh);
`ifdef CBFP_ROUND_EN
        r = (s + (longint'(1) << (DATA_W - OUT_W - 1))) >>> (DATA_W - OUT_W);
        if (r > (longint'(1) << (OUT_W - 1)) - 1) r = (longint'(1) << (OUT_W - 1)) - 1;
`else
        r = s >>> (DATA_W - OUT_W);
`endif
        return r[OUT_W-1:0];
    endfunction

    task automatic push_expected();
        int               m;
        logic [IDX_W-1:0] mi;
        m = DATA_W - 1;
        for (int k = 0; k < BLOCK_LEN; k++) begin
            if (lsb_model(blk_re[k]) < m) m = lsb_model(blk_re[k]);
            if (lsb_model(blk_im[k]) < m) m = lsb_model(blk_im[k]);
        end
        mi = IDX_W'(m);
        for (int k = 0; k < BLOCK_LEN; k++) begin
            exp_q.push_back({(k == BLOCK_LEN - 1), mi,
                             narrow_model(blk_re[k], m), narrow_model(blk_im[k], m)});
        end
    endtask

    // ---------------- driver tasks ----------------
    // Called just after a rising edge; returns 1 time unit after the edge
    // that captured the last sample (i.e. inside the first EMIT cycle).
    task automatic send_block(input int gap_max);
        int ng;
        push_expected();
        alert_cbfp = 1'b1;
        in_valid   = 1'b1;
        in_re      = blk_re[0];
        in_im      = blk_im[0];
        for (int k = 1; k < BLOCK_LEN; k++) begin
            @(posedge clk); #1;
            alert_cbfp = 1'b0;
            check("busy_collect", busy, 1);
            ng = $urandom_range(0, gap_max);
            repeat (ng) begin
                in_valid = 1'b0;
                in_re    = DATA_W'($urandom);
                in_im    = DATA_W'($urandom);
                @(posedge clk); #1;
                check("busy_gap", busy, 1);
            end
            in_valid = 1'b1;
            in_re    = blk_re[k];
            in_im    = blk_im[k];
        end
        @(posedge clk); #1;
        alert_cbfp = 1'b0;
        in_valid   = 1'b0;
        check("busy_emit", busy, 1);
    endtask

    task automatic check_latency();
        @(negedge clk);
        check("lat_t_plus_1_valid", out_valid, 0);
        @(negedge clk);
        check("lat_t_plus_2_valid", out_valid, 1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy) check("idle_timeout", busy, 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic fill_const(input logic [DATA_W-1:0] re, input logic [DATA_W-1:0] im);
        for (int k = 0; k < BLOCK_LEN; k++) begin
            blk_re[k] = re;
            blk_im[k] = im;
        end
    endtask

    task automatic fill_random();
        int                       base;
        int                       sh;
        logic signed [DATA_W-1:0] t;
        base = $urandom_range(0, DATA_W - 1);
        for (int k = 0; k < BLOCK_LEN; k++) begin
            t  = DATA_W'($urandom);
            sh = base + $urandom_range(0, 3);
            if (sh > DATA_W - 1) sh = DATA_W - 1;
            blk_re[k] = t >>> sh;
            t  = DATA_W'($urandom);
            sh = base + $urandom_range(0, 3);
            if (sh > DATA_W - 1) sh = DATA_W - 1;
            blk_im[k] = t >>> sh;
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [EXP_W-1:0] got;
        logic [EXP_W-1:0] want;
        if (!rstn) begin
            run_len = 0;
        end else if (out_valid) begin
            run_len++;
            got = {out_last, out_idx, out_re, out_im};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out: got last=%0d idx=%0d re=%0d im=%0d expected no output",
                         out_last, out_idx, $signed(out_re), $signed(out_im));
            end else begin
                want = exp_q.pop_front();
                if (got != want) begin
                    errors++;
                    $display("FAIL out_sample: got last=%0d idx=%0d re=%0d im=%0d expected last=%0d idx=%0d re=%0d im=%0d",
                             got[EXP_W-1], got[2*OUT_W +: IDX_W],
                             $signed(got[OUT_W +: OUT_W]), $signed(got[0 +: OUT_W]),
                             want[EXP_W-1], want[2*OUT_W +: IDX_W],
                             $signed(want[OUT_W +: OUT_W]), $signed(want[0 +: OUT_W]));
                end
            end
        end else begin
            check("last_low_when_idle", out_last, 0);
            if (run_len != 0) check("burst_len", run_len, BLOCK_LEN);
            run_len = 0;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int n;
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_re", out_re, 0);
        check("rst_out_im", out_im, 0);
        check("rst_out_idx", out_idx, 0);
        check("rst_out_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_ovf", ovf, 0);
        rstn = 1'b1;
        @(posedge clk); #1;

        // Samples without an alert are ignored.
        repeat (4) begin
            in_valid = 1'b1;
            in_re    = DATA_W'($urandom);
            in_im    = DATA_W'($urandom);
            @(posedge clk); #1;
            check("stray_busy", busy, 0);
        end
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // re=1024, im=0: shift 11, out_re 512.
        fill_const(DATA_W'(1024), '0);
        send_block(0);
        check_latency();
        wait_idle();

        // Same data with random gaps.
        send_block(3);
        check_latency();
        wait_idle();

        // One near-full-scale sample forces shift 0.
        fill_const(DATA_W'(23'h000800), DATA_W'(23'h000800));
        blk_re[3] = DATA_W'(23'h3FFFFF);
        send_block(1);
        wait_idle();

        // All zeros and all -1: shift 22.
        fill_const('0, '0);
        send_block(0);
        wait_idle();
        fill_const('1, '1);
        send_block(2);
        wait_idle();

        // Random magnitudes.
        repeat (6) begin
            fill_random();
            send_block($urandom_range(0, 2));
            wait_idle();
        end

        // Inputs during EMIT are dropped and set ovf; back-to-back alert on
        // the cycle the last sample is loaded starts the next block.
        fill_random();
        send_block(0);
        for (int c = 1; c < BLOCK_LEN - 1; c++) begin
            @(posedge clk); #1;
            in_valid   = (c == 3);
            alert_cbfp = (c == 5);
            in_re      = DATA_W'($urandom);
            in_im      = DATA_W'($urandom);
        end
        @(posedge clk); #1;
        check("ovf_set", ovf, 1);
        fill_random();
        send_block(1);
        wait_idle();
        check("ovf_sticky", ovf, 1);

        // Reset after 7 collected samples discards the partial block.
        fill_random();
        alert_cbfp = 1'b1;
        in_valid   = 1'b1;
        in_re      = blk_re[0];
        in_im      = blk_im[0];
        for (int k = 1; k < 7; k++) begin
            @(posedge clk); #1;
            alert_cbfp = 1'b0;
            in_re      = blk_re[k];
            in_im      = blk_im[k];
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        rstn     = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_ovf", ovf, 0);
        check("midrst_out_re", out_re, 0);
        check("midrst_out_idx", out_idx, 0);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;
        fill_random();
        send_block(2);
        check_latency();
        wait_idle();
        check("post_rst_ovf", ovf, 0);

        // Drain the scoreboard with a bounded wait.
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        check("leftover_expected", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
